noc_stream_collector: RTL and testbench
=======================================

Name: noc_stream_collector

Overview:
- Parametrised successor to the FPT'23 collector. It receives an AXI-Stream flit from a NoC router port and reduces each byte lane to one bit under a selectable mode.
- Reduced words are buffered in a parametrised-depth FIFO and presented on a first-word-fall-through (FWFT) valid/ready output port.
- It tracks tlast so consumers can see packet boundaries and the number of complete packets buffered.
- It sits between the NoC slave interface and the user compute tile.

Parameters:
- NOC_DW, 512, NoC data width in bits; must be a multiple of BYTE_DW.
- BYTE_DW, 8, bits per reduction lane.
- USER_DW, 32, tuser width; accepted and ignored.
- DEPTH, 512, FIFO capacity in words; power of two, at least 4.
- REDUCE_MODE, 0, lane reduction: 0 = XOR (parity), 1 = OR (lane non-zero), 2 = AND (lane all-ones).
- Derived: LANES = NOC_DW/BYTE_DW; CW = $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_tvalid  in  1  input flit valid.
- rx_tdata  in  NOC_DW  input flit data.
- rx_tstrb  in  LANES  accepted and ignored.
- rx_tkeep  in  LANES  byte keep; used only under the optional feature.
- rx_tid  in  BYTE_DW  accepted and ignored.
- rx_tdest  in  BYTE_DW  accepted and ignored.
- rx_tuser  in  USER_DW  accepted and ignored.
- rx_tlast  in  1  last flit of packet.
- rx_tready  out  1  collector can accept a flit.
- ofifo_rdata  out  LANES  head reduced word.
- ofifo_last  out  1  head word carries tlast.
- ofifo_valid  out  1  head word valid.
- ofifo_ren  in  1  consumer pops the head word.
- ofifo_count  out  CW  words held.
- ofifo_pkts  out  CW  complete packets held.

Behaviour:
- Reset: rx_tready=0 during reset and 1 in the first cycle after it. ofifo_valid=0, ofifo_rdata=0, ofifo_last=0, ofifo_count=0, ofifo_pkts=0. All pointers are 0.
- Reset mid-operation discards all contents; no partial state survives.
- Reduction is done before storage: lane i = reduce(rx_tdata[i*BYTE_DW +: BYTE_DW]). The stored word is {tlast, LANES bits}. Storage is a RAM with synchronous read and 1-cycle read latency, plus a 2-entry output stage (head register + skid register).
- Push = rx_tvalid && rx_tready. rx_tready = (ofifo_count < DEPTH). rx_tready does not depend on ofifo_ren, so there is no push when full even if a pop happens in the same cycle.
- Pop = ofifo_valid && ofifo_ren. ofifo_ren while ofifo_valid=0 is ignored, with no state change.
- Latency: a word pushed at edge N appears with ofifo_valid=1 at N+2 when the FIFO is empty. There is no bypass path.
- Throughput: sustained 1 push and 1 pop per cycle indefinitely when ofifo_ren is held high. The prefetch issues a RAM read whenever the RAM is non-empty and the output stage has, or will have after this cycle's pop, a free slot.
- Order: strict FIFO. The head register always holds the oldest word; the skid register refills it on pop.
- ofifo_count: total words held in RAM, output stage and in-flight read. It is +1 on push only, -1 on pop only, and unchanged on both. Its range is 0..DEPTH.
- ofifo_pkts: +1 on a push with rx_tlast=1, -1 on a pop with ofifo_last=1, and unchanged on both.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from the count, never from pointer equality.
- Outputs are held stable while ofifo_valid=1 and no pop occurs.

Optional Feature:
- Macro: NOC_COLLECTOR_TKEEP_MASK_EN.
- Defined: a lane with rx_tkeep[i]=0 is treated as all-zero data before reduction. For XOR/OR the lane result is 0; for AND it is 0.
- Undefined: rx_tkeep is ignored and every lane reduces its raw data.

Test Plan:
- Reset, then push tdata = 512'h01 (lane0 = 8'h01) with tlast=1, REDUCE_MODE=0 -> at edge N+2 ofifo_valid=1, ofifo_rdata=64'h1, ofifo_last=1, ofifo_count=1, ofifo_pkts=1.
- DEPTH=8, ofifo_ren=0, push 10 flits back-to-back -> exactly 8 accepted. rx_tready=0 once ofifo_count=8. Pop one -> rx_tready=1 on the next cycle, count 7 before the refill.
- Push 1000 flits and pop continuously, both at 1/cycle with DEPTH=8 -> 1000 words out in order, zero stall cycles after fill, wrap exercised, count never exceeds 3.
- REDUCE_MODE=1 with lane3=8'h80 and the rest 0 -> ofifo_rdata=64'h8. REDUCE_MODE=2 with all lanes 8'hFF -> 64'hFFFF_FFFF_FFFF_FFFF.
- Macro defined, REDUCE_MODE=0, tdata all 8'h01 lanes, tkeep=64'h0000_0000_0000_00FF -> ofifo_rdata=64'hFF. Macro undefined -> 64'hFFFF_FFFF_FFFF_FFFF.
- Push 3 words (tlast on word 3), then assert rst mid-stream for 1 cycle -> all outputs 0, count and pkts 0. A following single push is read back correctly at N+2.

Source files
------------

// File: rtl/noc_stream_collector_if.sv
// Bundle of the NoC AXI-Stream receive side and the FWFT output port of the stream collector.
interface noc_stream_collector_if #(
  parameter int NOC_DW  = 512,
  parameter int BYTE_DW = 8,
  parameter int USER_DW = 32,
  parameter int DEPTH   = 512
);
  localparam int LANES = NOC_DW / BYTE_DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               rx_tvalid;
  logic [NOC_DW-1:0]  rx_tdata;
  logic [LANES-1:0]   rx_tstrb;
  logic [LANES-1:0]   rx_tkeep;
  logic [BYTE_DW-1:0] rx_tid;
  logic [BYTE_DW-1:0] rx_tdest;
  logic [USER_DW-1:0] rx_tuser;
  logic               rx_tlast;
  logic               rx_tready;
  logic [LANES-1:0]   ofifo_rdata;
  logic               ofifo_last;
  logic               ofifo_valid;
  logic               ofifo_ren;
  logic [CW-1:0]      ofifo_count;
  logic [CW-1:0]      ofifo_pkts;

  // collector side
  modport slave (
    input  rx_tvalid, rx_tdata, rx_tstrb, rx_tkeep, rx_tid, rx_tdest, rx_tuser, rx_tlast, ofifo_ren,
    output rx_tready, ofifo_rdata, ofifo_last, ofifo_valid, ofifo_count, ofifo_pkts
  );

  // router / compute-tile side
  modport master (
    output rx_tvalid, rx_tdata, rx_tstrb, rx_tkeep, rx_tid, rx_tdest, rx_tuser, rx_tlast, ofifo_ren,
    input  rx_tready, ofifo_rdata, ofifo_last, ofifo_valid, ofifo_count, ofifo_pkts
  );
endinterface

// File: rtl/noc_stream_collector.sv
// NoC stream collector: per-byte-lane reduction into a RAM FIFO with FWFT head/skid output stage.
// Optional NOC_COLLECTOR_TKEEP_MASK_EN: lanes with tkeep=0 reduce as all-zero data.

module noc_collector_lane #(
  parameter int BYTE_DW     = 8,
  parameter int REDUCE_MODE = 0
) (
  input  logic [BYTE_DW-1:0] lane_i,
  input  logic               keep_i,
  output logic               bit_o
);
  logic [BYTE_DW-1:0] masked;
  assign masked = keep_i ? lane_i : '0;

  generate
    if (REDUCE_MODE == 1) begin : g_or
      assign bit_o = |masked;
    end else if (REDUCE_MODE == 2) begin : g_and
      assign bit_o = &masked;
    end else begin : g_xor
      assign bit_o = ^masked;
    end
  endgenerate
endmodule

module noc_stream_collector #(
  parameter int NOC_DW      = 512,
  parameter int BYTE_DW     = 8,
  parameter int USER_DW     = 32,
  parameter int DEPTH       = 512,
  parameter int REDUCE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  noc_stream_collector_if.slave bus
);
  localparam int LANES = NOC_DW / BYTE_DW;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef struct packed {
    logic             last;
    logic [LANES-1:0] bits;
  } word_t;

  logic [LANES-1:0] keep;
  logic [LANES-1:0] red;

`ifdef NOC_COLLECTOR_TKEEP_MASK_EN
  assign keep = bus.rx_tkeep;
  logic unused_sb;
  assign unused_sb = ^{bus.rx_tstrb, bus.rx_tid, bus.rx_tdest};
`else
  assign keep = '1;
  logic unused_sb;
  assign unused_sb = ^{bus.rx_tstrb, bus.rx_tkeep, bus.rx_tid, bus.rx_tdest};
`endif
  logic [USER_DW-1:0] unused_tuser;
  assign unused_tuser = bus.rx_tuser;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      noc_collector_lane #(.BYTE_DW(BYTE_DW), .REDUCE_MODE(REDUCE_MODE)) u_lane (
        .lane_i (bus.rx_tdata[gi*BYTE_DW +: BYTE_DW]),
        .keep_i (keep[gi]),
        .bit_o  (red[gi])
      );
    end
  endgenerate

  word_t          mem [DEPTH];
  word_t          rd_data_q;
  word_t          head_q, head_d, skid_q, skid_d;
  logic           head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  ram_cnt_q, ram_cnt_d, count_q, count_d, pkts_q, pkts_d;
  logic           rd_inflight_q, rdy_q;
  logic           push, pop, rd_en, pkt_in, pkt_out;
  logic [2:0]     stage_n;

  assign push    = bus.rx_tvalid && rdy_q;
  assign pop     = head_v_q && bus.ofifo_ren;
  assign pkt_in  = push && bus.rx_tlast;
  assign pkt_out = pop && head_q.last;

  // Occupancy of the output stage once this cycle's pop and landing read settle;
  // a new read is only issued if its word is guaranteed a slot next cycle.
  assign stage_n = 3'(head_v_q) + 3'(skid_v_q) + 3'(rd_inflight_q) - 3'(pop);
  assign rd_en   = (ram_cnt_q != '0) && (stage_n < 3'd2);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{last: bus.rx_tlast, bits: red};
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  always_comb begin
    head_v_d = head_v_q;
    head_d   = head_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (pop) begin
      head_v_d = skid_v_q;
      head_d   = skid_q;
      skid_v_d = 1'b0;
    end
    if (rd_inflight_q) begin
      if (!head_v_d) begin
        head_v_d = 1'b1;
        head_d   = rd_data_q;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = rd_data_q;
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    ram_cnt_d = ram_cnt_q;
    pkts_d    = pkts_q;
    if (push && !pop)         count_d = count_q + CW'(1);
    else if (pop && !push)    count_d = count_q - CW'(1);
    if (push && !rd_en)       ram_cnt_d = ram_cnt_q + CW'(1);
    else if (rd_en && !push)  ram_cnt_d = ram_cnt_q - CW'(1);
    if (pkt_in && !pkt_out)   pkts_d = pkts_q + CW'(1);
    else if (pkt_out && !pkt_in) pkts_d = pkts_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      count_q       <= '0;
      pkts_q        <= '0;
      rd_inflight_q <= 1'b0;
      rdy_q         <= 1'b0;
      head_v_q      <= 1'b0;
      skid_v_q      <= 1'b0;
      head_q        <= '0;
      skid_q        <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      ram_cnt_q     <= ram_cnt_d;
      count_q       <= count_d;
      pkts_q        <= pkts_d;
      rd_inflight_q <= rd_en;
      // Full is judged on the count only, so a same-cycle pop never opens the input.
      rdy_q         <= (count_d < CW'(DEPTH));
      head_v_q      <= head_v_d;
      skid_v_q      <= skid_v_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
    end
  end

  assign bus.rx_tready   = rdy_q;
  assign bus.ofifo_valid = head_v_q;
  assign bus.ofifo_rdata = head_q.bits;
  assign bus.ofifo_last  = head_q.last;
  assign bus.ofifo_count = count_q;
  assign bus.ofifo_pkts  = pkts_q;
endmodule

// File: tb/tb_noc_stream_collector.sv
// Bench: three collectors (XOR/OR/AND) with DEPTH=8 share one stimulus and one queue model.
module tb_noc_stream_collector;
  localparam int DEPTH = 8;
`ifdef NOC_COLLECTOR_TKEEP_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic         clk, rst, tvalid, tlast, ren;
  logic [511:0] tdata;
  logic [63:0]  tkeep;

  noc_stream_collector_if #(.NOC_DW(512), .BYTE_DW(8), .USER_DW(32), .DEPTH(DEPTH)) b0 (), b1 (), b2 ();

  assign b0.rx_tvalid = tvalid; assign b0.rx_tdata = tdata; assign b0.rx_tkeep = tkeep;
  assign b0.rx_tlast = tlast;   assign b0.ofifo_ren = ren;  assign b0.rx_tstrb = '0;
  assign b0.rx_tid = '0;        assign b0.rx_tdest = '0;    assign b0.rx_tuser = '0;
  assign b1.rx_tvalid = tvalid; assign b1.rx_tdata = tdata; assign b1.rx_tkeep = tkeep;
  assign b1.rx_tlast = tlast;   assign b1.ofifo_ren = ren;  assign b1.rx_tstrb = '0;
  assign b1.rx_tid = '0;        assign b1.rx_tdest = '0;    assign b1.rx_tuser = '0;
  assign b2.rx_tvalid = tvalid; assign b2.rx_tdata = tdata; assign b2.rx_tkeep = tkeep;
  assign b2.rx_tlast = tlast;   assign b2.ofifo_ren = ren;  assign b2.rx_tstrb = '0;
  assign b2.rx_tid = '0;        assign b2.rx_tdest = '0;    assign b2.rx_tuser = '0;

  noc_stream_collector #(.NOC_DW(512), .BYTE_DW(8), .USER_DW(32), .DEPTH(DEPTH), .REDUCE_MODE(0))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  noc_stream_collector #(.NOC_DW(512), .BYTE_DW(8), .USER_DW(32), .DEPTH(DEPTH), .REDUCE_MODE(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  noc_stream_collector #(.NOC_DW(512), .BYTE_DW(8), .USER_DW(32), .DEPTH(DEPTH), .REDUCE_MODE(2))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  bit chk_en = 0, streaming = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---- model: FIFO of raw flits, each visible two edges after its push ----
  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    int           t;
  } ent_t;
  ent_t q[$];
  int cyc = 0, acc_cnt = 0, dut_pops = 0;
  bit was_rst = 1;

  function automatic logic [63:0] reduce(input int mode, input logic [511:0] d, input logic [63:0] k);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      b = d[i*8 +: 8];
      if (MASK && !k[i]) b = 8'h00;
      case (mode)
        1:       r[i] = (b != 8'h00);
        2:       r[i] = (b == 8'hFF);
        default: r[i] = ^b;
      endcase
    end
    return r;
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && (cyc >= q[0].t + 2);
  endfunction
  function automatic bit exp_ready();
    return !was_rst && (q.size() < DEPTH);
  endfunction
  function automatic int exp_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit do_pop, do_push;
    do_pop  = exp_valid() && ren;
    do_push = tvalid && exp_ready();
    if (b0.ofifo_valid && ren) dut_pops++;
    cyc++;
    if (rst) begin
      q.delete();
      was_rst = 1;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{d: tdata, k: tkeep, l: tlast, t: cyc});
        acc_cnt++;
      end
      was_rst = 0;
    end
  end

  task automatic cmp(input string nm, input int mode, input logic rdy, input logic v,
                     input logic [63:0] rd, input logic l, input logic [3:0] c, input logic [3:0] p);
    chk({nm, ".tready"}, rdy, exp_ready());
    chk({nm, ".valid"}, v, exp_valid());
    chk({nm, ".count"}, c, q.size());
    chk({nm, ".pkts"}, p, exp_pkts());
    if (exp_valid()) begin
      chk({nm, ".rdata"}, rd, reduce(mode, q[0].d, q[0].k));
      chk({nm, ".last"}, l, q[0].l);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("xor", 0, b0.rx_tready, b0.ofifo_valid, b0.ofifo_rdata, b0.ofifo_last, b0.ofifo_count, b0.ofifo_pkts);
      cmp("or",  1, b1.rx_tready, b1.ofifo_valid, b1.ofifo_rdata, b1.ofifo_last, b1.ofifo_count, b1.ofifo_pkts);
      cmp("and", 2, b2.rx_tready, b2.ofifo_valid, b2.ofifo_rdata, b2.ofifo_last, b2.ofifo_count, b2.ofifo_pkts);
      if (streaming) chk("stream.count_le3", b0.ofifo_count <= 4'd3, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    ren = 1'b1;
    while (b0.ofifo_count != 0 && n < 100) begin
      tick();
      n++;
    end
    ren = 1'b0;
    chk({nm, ".drained"}, b0.ofifo_count, 0);
  endtask

  initial begin
    int a0, p0, k;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; ren = 1'b0; tdata = '0; tkeep = '1;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst.tready", b0.rx_tready, 0);
    chk("rst.valid", b0.ofifo_valid, 0);
    chk("rst.rdata", b0.ofifo_rdata, 0);
    chk("rst.count", b0.ofifo_count, 0);
    chk("rst.pkts", b0.ofifo_pkts, 0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst.tready_after", b0.rx_tready, 1);

    // single word latency, XOR mode
    tick();
    tdata = 512'h01; tlast = 1'b1; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    @(negedge clk);
    chk("lat.n1_valid", b0.ofifo_valid, 0);
    tick();
    @(negedge clk);
    chk("lat.valid", b0.ofifo_valid, 1);
    chk("lat.rdata", b0.ofifo_rdata, 64'h1);
    chk("lat.last", b0.ofifo_last, 1);
    chk("lat.count", b0.ofifo_count, 1);
    chk("lat.pkts", b0.ofifo_pkts, 1);
    drain("lat");

    // reduction modes
    tick();
    tdata = '0; tdata[31:24] = 8'h80; tvalid = 1'b1;
    tick();
    tdata = {64{8'hFF}};
    tick();
    tvalid = 1'b0;
    tick();
    @(negedge clk);
    chk("mode.or_lane3", b1.ofifo_rdata, 64'h8);
    chk("mode.xor_lane3", b0.ofifo_rdata, 64'h8);
    chk("mode.and_lane3", b2.ofifo_rdata, 64'h0);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    @(negedge clk);
    chk("mode.and_allff", b2.ofifo_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mode.xor_allff", b0.ofifo_rdata, 64'h0);
    drain("mode");

    // tkeep masking
    tick();
    tdata = {64{8'h01}}; tkeep = 64'hFF; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tkeep = '1;
    tick();
    tick();
    @(negedge clk);
    chk("tkeep.xor", b0.ofifo_rdata, MASK ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF);
    drain("tkeep");

    // fill to full with ren low
    tick();
    a0 = acc_cnt;
    tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tdata = 512'(i * 37 + 5); tlast = (i % 3 == 2);
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk);
    chk("full.accepted", acc_cnt - a0, 8);
    chk("full.tready", b0.rx_tready, 0);
    chk("full.count", b0.ofifo_count, 8);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    @(negedge clk);
    chk("full.tready_after_pop", b0.rx_tready, 1);
    chk("full.count_after_pop", b0.ofifo_count, 7);
    drain("full");

    // sustained streaming with wrap
    tick();
    a0 = acc_cnt; p0 = dut_pops; k = 0;
    streaming = 1; ren = 1'b1; tvalid = 1'b1;
    tdata = {16{32'hA5C3_0F1E}}; tlast = 1'b0;
    for (int n = 0; n < 2000 && (acc_cnt - a0) < 1000; n++) begin
      tick();
      if (acc_cnt - a0 != k) begin
        k = acc_cnt - a0;
        tdata = {16{32'(k) * 32'h9E37_79B1 ^ 32'hA5C3_0F1E}};
        tlast = (k % 5 == 4);
      end
      if (k >= 1000) tvalid = 1'b0;
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("stream.accepted", acc_cnt - a0, 1000);
    drain("stream");
    streaming = 0;
    chk("stream.popped", dut_pops - p0, 1000);

    // reset mid-stream
    tick();
    tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tdata = 512'(i + 3); tlast = (i == 2);
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid.pkts_before", b0.ofifo_pkts, 1);
    chk("mid.count_before", b0.ofifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid.tready", b0.rx_tready, 0);
    chk("mid.valid", b0.ofifo_valid, 0);
    chk("mid.rdata", b0.ofifo_rdata, 0);
    chk("mid.last", b0.ofifo_last, 0);
    chk("mid.count", b0.ofifo_count, 0);
    chk("mid.pkts", b0.ofifo_pkts, 0);
    tick();
    tdata = '0; tdata[47:40] = 8'h07; tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid.push_valid", b0.ofifo_valid, 1);
    chk("mid.push_xor", b0.ofifo_rdata, 64'h20);
    chk("mid.push_or", b1.ofifo_rdata, 64'h20);
    chk("mid.push_and", b2.ofifo_rdata, 64'h0);
    drain("mid");
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
